vga_timing_monitor: RTL and testbench

//  Downstream consumer of vga_controller (640x480@60, 25 MHz pixel clock). Samples h_sync,
//  v_sync and RGB on the same clk. Measures line/frame periods and sync widths. Checks the

---
 rtl/vga_timing_monitor_pkg.sv | 40 ++++
 rtl/vga_timing_monitor_if.sv | 13 +
 rtl/vga_timing_monitor_sync_meter.sv | 76 +++++++
 rtl/vga_timing_monitor.sv | 186 ++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_monitor_pkg.sv
// vga_timing_monitor_pkg: 640x480@60 timing defaults, counter width,
// lock FSM states and the pixel-window helper shared by the monitor.
package vga_timing_monitor_pkg;

  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_ACT   = 480;

  localparam logic       VGA_SYNC_POL    = 1'b0;
  localparam logic [2:0] VGA_EXP_COLOR   = 3'b101;
  localparam int         VGA_LOCK_FRAMES = 2;

  localparam int CW = 10;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [2:0]    rgb_t;

  localparam cnt_t CNT_MAX = {CW{1'b1}};
  localparam cnt_t CNT_PRE = CNT_MAX - cnt_t'(1);

  typedef enum logic [1:0] {
    LK_UNSEEN,
    LK_ACQUIRE,
    LK_LOCKED
  } lock_state_t;

  function automatic logic in_win(
    input cnt_t pos,
    input int   lo,
    input int   len
  );
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_monitor_if.sv
// vga_timing_monitor_if: sync + colour bundle from a VGA source.
// master drives h_sync/v_sync/RGB, slave (the monitor) samples them.
interface vga_timing_monitor_if;
  import vga_timing_monitor_pkg::*;

  logic h_sync;
  logic v_sync;
  rgb_t RGB;

  modport master (output h_sync, v_sync, RGB);
  modport slave  (input  h_sync, v_sync, RGB);

endinterface

// File: rtl/vga_timing_monitor_sync_meter.sv
// vga_sync_meter: edge detect, saturating position counter, period and
// width check of one sync signal; i_en selects what one count step means.
module vga_sync_meter
  import vga_timing_monitor_pkg::*;
#(
  parameter int   TOTAL = VGA_H_TOTAL,
  parameter int   SYNC  = VGA_H_SYNC,
  parameter logic POL   = VGA_SYNC_POL,
  parameter bit   TMO   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_sync,
  output logic o_assert_stb,
  output logic o_seen,
  output cnt_t o_pos,
  output logic o_period_err,
  output logic o_width_err
);

  localparam logic [CW:0] L_TOTAL = TOTAL[CW:0];
  localparam cnt_t        L_SYNC  = SYNC[CW-1:0];

  logic        r_prev;
  logic        r_seen;
  logic        r_tmo;
  cnt_t        r_pos;

  logic        w_act;
  logic        w_was;
  logic        w_deassert;
  logic        w_step;
  logic        w_tmo_hit;
  logic [CW:0] w_len;

  always_comb begin
    w_act        = (i_sync == POL);
    w_was        = (r_prev == POL);
    o_assert_stb = w_act & ~w_was;
    w_deassert   = ~w_act & w_was;
    w_step       = i_en & (r_pos != CNT_MAX);
    // span from the last assertion up to and including this step
    w_len        = {1'b0, r_pos} + {{CW{1'b0}}, i_en};
    o_pos        = r_pos;
    if (o_assert_stb)
      o_pos = '0;
    else if (w_step)
      o_pos = r_pos + cnt_t'(1);
    // fires once, on the step that lands on the saturation value
    w_tmo_hit    = TMO & r_seen & w_step & ~o_assert_stb
                 & (r_pos == CNT_PRE);
    // after a timeout the next assertion only restarts the count
    o_period_err = (o_assert_stb & r_seen & ~r_tmo
                    & (w_len != L_TOTAL))
                 | w_tmo_hit;
    o_width_err  = w_deassert & r_seen & (o_pos != L_SYNC);
    o_seen       = r_seen;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= ~POL;
      r_seen <= 1'b0;
      r_tmo  <= 1'b0;
      r_pos  <= '0;
    end else begin
      r_prev <= i_sync;
      r_pos  <= o_pos;
      if (o_assert_stb)
        r_seen <= 1'b1;
      r_tmo  <= ~o_assert_stb & (r_tmo | w_tmo_hit);
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: checks VGA sync timing and colour, pulses h/v/rgb
// errors, keeps a saturating error count and a clean-frame lock flag.
module vga_timing_monitor
  import vga_timing_monitor_pkg::*;
#(
  parameter int         H_TOTAL     = VGA_H_TOTAL,
  parameter int         H_SYNC      = VGA_H_SYNC,
  parameter int         H_BP        = VGA_H_BP,
  parameter int         H_ACT       = VGA_H_ACT,
  parameter int         V_TOTAL     = VGA_V_TOTAL,
  parameter int         V_SYNC      = VGA_V_SYNC,
  parameter int         V_BP        = VGA_V_BP,
  parameter int         V_ACT       = VGA_V_ACT,
  parameter logic       SYNC_POL    = VGA_SYNC_POL,
  parameter logic [2:0] EXP_COLOR   = VGA_EXP_COLOR,
  parameter int         LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_timing_monitor_if.slave  vga,
  output logic                 frame_done,
  output logic                 h_err,
  output logic                 v_err,
  output logic                 rgb_err,
  output logic [7:0]           err_count,
  output logic                 locked
);

  localparam logic [7:0] L_LOCK = LOCK_FRAMES[7:0];

  cnt_t        w_p;
  cnt_t        w_l;
  logic        w_h_ast;
  logic        w_h_seen;
  logic        w_h_perr;
  logic        w_h_werr;
  logic        w_v_ast;
  logic        w_v_seen;
  logic        w_v_perr;
  logic        w_v_werr;

  logic        w_win;
  rgb_t        w_exp;
  logic        w_mis;
  logic        w_flag;
  logic        w_h_nxt;
  logic        w_v_nxt;
  logic        w_rgb_nxt;
  logic [8:0]  w_sum;
  logic        w_any;

  logic        r_fd;
  logic        r_h_err;
  logic        r_v_err;
  logic        r_rgb_err;
  logic        r_line_flag;
  logic [7:0]  r_cnt;

  lock_state_t r_state;
  lock_state_t w_state_nxt;
  logic [7:0]  r_clean;
  logic [7:0]  w_clean_nxt;
  logic        r_dirty;
  logic        w_dirty_nxt;

  vga_sync_meter #(
    .TOTAL (H_TOTAL),
    .SYNC  (H_SYNC),
    .POL   (SYNC_POL),
    .TMO   (1'b1)
  ) u_h (
    .clk          (clk),
    .reset        (reset),
    .i_en         (1'b1),
    .i_sync       (vga.h_sync),
    .o_assert_stb (w_h_ast),
    .o_seen       (w_h_seen),
    .o_pos        (w_p),
    .o_period_err (w_h_perr),
    .o_width_err  (w_h_werr)
  );

  // vertical meter steps once per line
  vga_sync_meter #(
    .TOTAL (V_TOTAL),
    .SYNC  (V_SYNC),
    .POL   (SYNC_POL),
    .TMO   (1'b0)
  ) u_v (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_h_ast),
    .i_sync       (vga.v_sync),
    .o_assert_stb (w_v_ast),
    .o_seen       (w_v_seen),
    .o_pos        (w_l),
    .o_period_err (w_v_perr),
    .o_width_err  (w_v_werr)
  );

  always_comb begin
    w_win     = in_win(w_p, H_SYNC + H_BP, H_ACT)
              & in_win(w_l, V_SYNC + V_BP, V_ACT);
    w_exp     = w_win ? EXP_COLOR : 3'b000;
    w_mis     = w_h_seen & w_v_seen & (vga.RGB != w_exp);
    // the assertion cycle already belongs to the new line
    w_flag    = r_line_flag & ~w_h_ast;
    w_rgb_nxt = w_mis & ~w_flag;
    w_h_nxt   = w_h_perr | w_h_werr;
    w_v_nxt   = w_v_perr | w_v_werr;
    w_sum     = {1'b0, r_cnt} + 9'(w_h_nxt)
              + 9'(w_v_nxt) + 9'(w_rgb_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd        <= 1'b0;
      r_h_err     <= 1'b0;
      r_v_err     <= 1'b0;
      r_rgb_err   <= 1'b0;
      r_line_flag <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_fd        <= w_v_ast & w_v_seen;
      r_h_err     <= w_h_nxt;
      r_v_err     <= w_v_nxt;
      r_rgb_err   <= w_rgb_nxt;
      r_line_flag <= w_flag | w_mis;
      r_cnt       <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clean_nxt = r_clean;
    w_dirty_nxt = r_dirty;
    w_any       = r_h_err | r_v_err | r_rgb_err;
    if (w_any) begin
      w_state_nxt = LK_ACQUIRE;
      w_clean_nxt = '0;
      w_dirty_nxt = 1'b1;
    end else if (r_fd) begin
      w_dirty_nxt = 1'b0;
      unique case (r_state)
        LK_UNSEEN: begin
          // no earlier frame_done, so this frame cannot count
          w_state_nxt = LK_ACQUIRE;
          w_clean_nxt = '0;
        end
        LK_ACQUIRE: begin
          if (!r_dirty) begin
            w_clean_nxt = r_clean + 8'd1;
            if (w_clean_nxt >= L_LOCK)
              w_state_nxt = LK_LOCKED;
          end
        end
        LK_LOCKED: begin
          w_state_nxt = LK_LOCKED;
        end
        default: begin
          w_state_nxt = LK_UNSEEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LK_UNSEEN;
      r_clean <= '0;
      r_dirty <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clean <= w_clean_nxt;
      r_dirty <= w_dirty_nxt;
    end
  end

  assign frame_done = r_fd;
  assign h_err      = r_h_err;
  assign v_err      = r_v_err;
  assign rgb_err    = r_rgb_err;
  assign err_count  = r_cnt;
  assign locked     = (r_state == LK_LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed bench on a reduced 40x12 raster
// (sync 4/2, back porch 4/2, active 24x6), active-low sync.
module tb_vga_timing_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_done;
  logic       h_err;
  logic       v_err;
  logic       rgb_err;
  logic [7:0] err_count;
  logic       locked;

  int cyc      = 0;
  int n_fd     = 0;
  int n_h      = 0;
  int n_v      = 0;
  int n_r      = 0;
  int last_h   = -1;
  int mark_cyc = 0;
  int total    = 0;
  int bad      = 0;
  int b_h, b_v, b_r, b_fd;

  always #20 clk = ~clk;

  vga_timing_monitor_if vif ();

  vga_timing_monitor #(
    .H_TOTAL     (40),
    .H_SYNC      (4),
    .H_BP        (4),
    .H_ACT       (24),
    .V_TOTAL     (12),
    .V_SYNC      (2),
    .V_BP        (2),
    .V_ACT       (6),
    .SYNC_POL    (1'b0),
    .EXP_COLOR   (3'b101),
    .LOCK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga        (vif),
    .frame_done (frame_done),
    .h_err      (h_err),
    .v_err      (v_err),
    .rgb_err    (rgb_err),
    .err_count  (err_count),
    .locked     (locked)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) n_fd++;
    if (v_err)      n_v++;
    if (rgb_err)    n_r++;
    if (h_err) begin
      n_h++;
      last_h = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_line(input int len, input bit vact, input bit vs,
                           input int bad_p, input int bad_n,
                           input logic [2:0] bad_c, input bit mark);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      if (mark && p == 0) mark_cyc = cyc + 1;
      vif.h_sync = (p < 4) ? 1'b0 : 1'b1;
      vif.v_sync = vs ? 1'b0 : 1'b1;
      vif.RGB    = (vact && p >= 8 && p < 32) ? 3'b101 : 3'b000;
      if (bad_p >= 0 && p >= bad_p && p < bad_p + bad_n)
        vif.RGB = bad_c;
    end
  endtask

  task automatic send_frame(input int vsw, input int bad_l,
                            input int bad_p, input int bad_n,
                            input logic [2:0] bad_c,
                            input int short_l, input int mark_l);
    for (int l = 0; l < 12; l++)
      send_line((l == short_l) ? 39 : 40, (l >= 4) && (l < 10), l < vsw,
                (l == bad_l) ? bad_p : -1, bad_n, bad_c, l == mark_l);
  endtask

  task automatic clean_frame();
    send_frame(2, -1, 0, 0, 3'b000, -1, -1);
  endtask

  task automatic snap();
    b_h  = n_h;
    b_v  = n_v;
    b_r  = n_r;
    b_fd = n_fd;
  endtask

  initial begin
    reset      = 1'b1;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    vif.RGB    = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_err_count", err_count, 0);
    check("rst_locked", locked, 0);
    check("rst_pulses", {frame_done, h_err, v_err, rgb_err}, 0);
    reset = 1'b0;

    // clean video: lock at the second frame_done after the first one
    snap();
    clean_frame();
    clean_frame();
    clean_frame();
    #1;
    check("t1_fd_after3", n_fd - b_fd, 2);
    check("t1_unlocked", locked, 0);
    clean_frame();
    #1;
    check("t1_fd_after4", n_fd - b_fd, 3);
    check("t1_locked", locked, 1);
    check("t1_err_count", err_count, 0);
    check("t1_no_events", (n_h - b_h) + (n_v - b_v) + (n_r - b_r), 0);

    // one 39-clock line
    snap();
    send_frame(2, -1, 0, 0, 3'b000, 5, 6);
    #1;
    check("t2_h_err_n", n_h - b_h, 1);
    check("t2_h_err_cyc", last_h, mark_cyc);
    check("t2_other", (n_v - b_v) + (n_r - b_r), 0);
    check("t2_lock_drop", locked, 0);
    check("t2_err_count", err_count, 1);
    clean_frame();
    clean_frame();
    #1;
    check("t2_relock_wait", locked, 0);
    clean_frame();
    #1;
    check("t2_relocked", locked, 1);

    // one wrong active pixel
    snap();
    send_frame(2, 5, 20, 1, 3'b100, -1, -1);
    #1;
    check("t3_rgb_n", n_r - b_r, 1);
    check("t3_err_count", err_count, 2);
    check("t3_lock_drop", locked, 0);

    // front porch colour run and a 3-line vsync
    snap();
    send_frame(3, 6, 32, 8, 3'b001, -1, -1);
    #1;
    check("t4_rgb_n", n_r - b_r, 1);
    check("t4_v_n", n_v - b_v, 1);
    check("t4_h_n", n_h - b_h, 0);
    check("t4_err_count", err_count, 4);

    // hsync timeout
    snap();
    send_frame(2, -1, 0, 0, 3'b000, -1, 11);
    repeat (1100) begin
      @(negedge clk);
      vif.h_sync = 1'b1;
      vif.v_sync = 1'b1;
      vif.RGB    = 3'b000;
    end
    #1;
    check("t5_tmo_n", n_h - b_h, 1);
    check("t5_tmo_cyc", last_h, mark_cyc + 1023);
    clean_frame();
    #1;
    check("t5_after_n", n_h - b_h, 1);
    check("t5_v_n", (n_v - b_v) + (n_r - b_r), 0);
    check("t5_err_count", err_count, 5);

    // reset mid-frame
    for (int l = 0; l < 5; l++)
      send_line(40, l >= 4, l < 2, -1, 0, 3'b000, 1'b0);
    @(negedge clk);
    reset      = 1'b1;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    vif.RGB    = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_rst_count", err_count, 0);
    check("t6_rst_locked", locked, 0);
    reset = 1'b0;
    snap();
    clean_frame();
    clean_frame();
    clean_frame();
    #1;
    check("t6_unlocked", locked, 0);
    clean_frame();
    #1;
    check("t6_locked", locked, 1);
    check("t6_no_events", (n_h - b_h) + (n_v - b_v) + (n_r - b_r), 0);
    check("t6_err_count", err_count, 0);

    // continuously bad lines: first adds 1, the rest add 2 each
    repeat (10) send_line(39, 1'b0, 1'b0, 0, 39, 3'b111, 1'b0);
    #1;
    check("t6_sum_19", err_count, 19);
    check("t6_bad_unlock", locked, 0);
    repeat (130) send_line(39, 1'b0, 1'b0, 0, 39, 3'b111, 1'b0);
    #1;
    check("t6_saturate", err_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
